custom_apb_master: RTL and testbench
====================================

# custom_apb_master

APB initiator that converts a simple valid/ready command interface into APB3 transfers. It drives one APB slave select and returns read data and a response status per transfer. It is the requester side of the peripheral bus: a test or DMA-style agent issues commands, and the block performs SETUP/ACCESS sequencing toward the custom APB peripherals, including wait-state and error handling.

## Interface
- ADDRWIDTH, 12, width of cmd_addr and PADDR
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles with PREADY low before abort (used only with the timeout feature; must be ≥ 1)
- PCLK  input  1  clock; all logic on rising edge
- PRESET  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a PCLK edge
- cmd_addr  input  ADDRWIDTH  byte address
- cmd_write  input  1  1 = write, 0 = read
- cmd_wdata  input  32  write data
- rsp_valid  output  1  one-cycle pulse: transfer finished
- rsp_rdata  output  32  captured PRDATA (reads); 0 for writes
- rsp_err  output  1  PSLVERR captured, or timeout abort
- PSEL, PENABLE, PWRITE  output  1 each  APB control
- PADDR  output  ADDRWIDTH  APB address
- PWDATA  output  32  APB write data
- PRDATA  input  32  APB read data
- PREADY  input  1  slave ready
- PSLVERR  input  1  slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: PSEL=0, PENABLE=0. On accept, register cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA, go SETUP.
- SETUP: PSEL=1, PENABLE=0, one cycle only, always go ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Transfer completes at an edge where PREADY=1. On completion, capture PRDATA (reads only, else 0) into rsp_rdata and PSLVERR into rsp_err, and set rsp_valid for the next cycle.
- After completion: if cmd_valid is high in the completion cycle, accept it and go directly to SETUP (back-to-back, PSEL stays 1). Otherwise go IDLE.
- cmd_ready = !PRESET & ((state==IDLE) | (state==ACCESS & completion)). It is combinational from state and PREADY.
- PADDR/PWRITE/PWDATA hold stable from SETUP through the final ACCESS cycle and keep their value in IDLE.
- Reset values: state IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err = 0; PADDR, PWDATA, rsp_rdata = 0; cmd_ready = 0 while PRESET=1.
- Reset mid-transfer (SETUP or ACCESS) abandons the transfer: no rsp_valid is produced, and the bus is idle the cycle after the reset edge.
- PREADY/PSLVERR/PRDATA are ignored outside ACCESS.

## Timing
- Command accepted at edge N → SETUP during cycle N+1 → ACCESS from cycle N+2.
- With zero wait states: completion at edge N+3, rsp_valid high during cycle N+3 (registered).
- Each PREADY-low cycle in ACCESS adds one cycle of latency.
- Back-to-back throughput: one transfer per 2 cycles minimum.
- rsp_valid has no back-pressure; the consumer must take it in its one-cycle window.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES with PREADY still 0, the transfer completes as aborted: rsp_err=1, rsp_rdata=0, rsp_valid pulses.
  - Normal completion rules (including back-to-back) apply.
  - If PREADY=1 in that same cycle, normal completion wins.
- Not defined: no counter exists, and ACCESS waits on PREADY indefinitely.

## Test plan
- Write, zero wait: cmd addr 0x000, wdata 0x00000003, accepted at edge N → PSEL=1/PENABLE=0 in cycle N+1, PENABLE=1 in N+2, rsp_valid in N+3 with rsp_err=0, rsp_rdata=0; PWRITE=1, PWDATA=0x3 stable across both cycles.
- Read, 3 wait states: PREADY low for 3 ACCESS cycles, then high with PRDATA=0x00000002 → rsp_valid at N+6, rsp_rdata=0x2; PADDR stable throughout.
- Slave error: read with PSLVERR=1 and PREADY=1 → rsp_err=1, rsp_rdata=PRDATA; the next transfer reports rsp_err=0.
- Back-to-back: two writes (0x000 then 0x004) with cmd_valid held → second SETUP in the cycle immediately after the first completion, PSEL never drops, two rsp_valid pulses 2 cycles apart.
- Reset mid-ACCESS: assert PRESET during a wait state → no rsp_valid; next cycle PSEL=PENABLE=0; a command after reset works normally.
- Timeout (macro defined, TIMEOUT_CYCLES=16): PREADY held 0 → abort after 16 ACCESS cycles with rsp_err=1, rsp_rdata=0, PSEL=0 next cycle. With the macro undefined, the bus remains in ACCESS after 1000 cycles.

Source files
------------

// File: rtl/custom_apb_master_if.sv
// rtl/custom_apb_master_if.sv - command/response and APB3 signal bundle for custom_apb_master
//
// Purpose : groups the requester-side command/response handshake and the APB3
//           bus of custom_apb_master into one interface.
// Modports:
//   master - the APB initiator (custom_apb_master): consumes commands and
//            slave responses, drives cmd_ready, rsp_* and the APB controls.
//   slave  - the environment: the command issuer plus the APB peripheral.
// Signals :
//   cmd_valid/cmd_ready/cmd_addr/cmd_write/cmd_wdata - command request
//   rsp_valid/rsp_rdata/rsp_err                      - per-transfer response
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA                 - APB request
//   PRDATA/PREADY/PSLVERR                            - APB completion
interface custom_apb_master_if #(
  parameter int ADDRWIDTH = 12
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic                 cmd_write;
  logic [31:0]          cmd_wdata;

  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;

  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [31:0]          PWDATA;
  logic [31:0]          PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/custom_apb_master.sv
// rtl/custom_apb_master.sv - APB3 initiator converting valid/ready commands into APB transfers
//
// Purpose : accepts one command at a time, runs the APB SETUP/ACCESS sequence
//           with wait-state support, and returns a one-cycle response pulse
//           carrying read data and error status.
// Ports   :
//   PCLK    - clock, all logic on the rising edge
//   PRESET  - synchronous active-high reset
//   bus     - custom_apb_master_if.master (command, response and APB signals)
// Params  :
//   ADDRWIDTH      - width of cmd_addr / PADDR
//   TIMEOUT_CYCLES - PREADY-low ACCESS cycles tolerated before abort (>= 1)
// Option  : APB_MASTER_TIMEOUT_EN - when defined, a stalled ACCESS phase is
//           aborted after TIMEOUT_CYCLES cycles and reported with rsp_err=1.
module custom_apb_master #(
  parameter int ADDRWIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  custom_apb_master_if.master  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("custom_apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [ADDRWIDTH-1:0] r_paddr;
  logic                 r_pwrite;
  logic [31:0]          r_pwdata;
  logic                 r_rsp_valid;
  logic [31:0]          r_rsp_rdata;
  logic                 r_rsp_err;

  logic w_timeout;
  logic w_complete;
  logic w_cmd_ready;
  logic w_accept;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;

  // r_wait_cnt holds the PREADY-low cycles already spent in this ACCESS
  // phase, so the abort fires in the TIMEOUT_CYCLES-th stalled cycle.
  assign w_timeout = (r_state == ACCESS) && !bus.PREADY &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Held at zero outside ACCESS, so every entry into ACCESS starts fresh,
  // including back-to-back transfers that pass through SETUP.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wait_cnt <= '0;
    end else if (r_state != ACCESS) begin
      r_wait_cnt <= '0;
    end else if (!bus.PREADY) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // PREADY wins over a coincident timeout because the abort term requires
  // PREADY low.
  assign w_complete  = (r_state == ACCESS) && (bus.PREADY || w_timeout);
  assign w_cmd_ready = !PRESET && ((r_state == IDLE) || w_complete);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = SETUP;
      end
      SETUP: begin
        w_next_state = ACCESS;
      end
      ACCESS: begin
        if (w_complete) w_next_state = w_accept ? SETUP : IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Address/data registers only load on accept, so they stay stable from
  // SETUP through the last ACCESS cycle and keep their value in IDLE.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else if (w_accept) begin
      r_paddr  <= bus.cmd_addr;
      r_pwrite <= bus.cmd_write;
      r_pwdata <= bus.cmd_wdata;
    end
  end

  // Response capture. A timeout abort is the only completion with PREADY
  // low, so PREADY selects between slave status and the abort result.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_complete;
      if (w_complete) begin
        r_rsp_rdata <= (bus.PREADY && !r_pwrite) ? bus.PRDATA : 32'd0;
        r_rsp_err   <= bus.PREADY ? bus.PSLVERR : 1'b1;
      end
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.PSEL      = (r_state == SETUP) || (r_state == ACCESS);
  assign bus.PENABLE   = (r_state == ACCESS);
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;

endmodule

// File: tb/tb_custom_apb_master.sv
// tb/tb_custom_apb_master.sv - directed self-checking bench for custom_apb_master
module tb_custom_apb_master;

  localparam int AW = 12;

  logic PCLK;
  logic PRESET;
  int   n_tests;
  int   n_fail;
  int   pulses;
  int   ready_seen;

  custom_apb_master_if #(.ADDRWIDTH(AW)) bus ();

  custom_apb_master #(
    .ADDRWIDTH      (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_write = wr;
    bus.cmd_wdata = wd;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    PRESET        = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 12'h0FC;
    bus.cmd_write = 1'b1;
    bus.cmd_wdata = 32'h1234_5678;
    bus.PRDATA    = 32'd0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;

    // Reset state, with a pending command that must not be accepted
    tick();
    tick();
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_psel_pen", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    check("rst_pwrite", {31'd0, bus.PWRITE}, 32'd0);
    check("rst_paddr", {20'd0, bus.PADDR}, 32'd0);
    check("rst_pwdata", bus.PWDATA, 32'd0);
    check("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    bus.cmd_valid = 1'b0;
    PRESET        = 1'b0;
    #1;
    check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Write, zero wait states
    send(12'h000, 1'b1, 32'h0000_0003);
    bus.PRDATA = 32'hDEAD_BEEF;
    tick();
    bus.cmd_valid = 1'b0;
    check("wr_setup_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd2);
    check("wr_setup_pwrite", {31'd0, bus.PWRITE}, 32'd1);
    check("wr_setup_pwdata", bus.PWDATA, 32'h3);
    check("wr_setup_ready", {31'd0, bus.cmd_ready}, 32'd0);
    tick();
    check("wr_access_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
    check("wr_access_pwdata", bus.PWDATA, 32'h3);
    check("wr_access_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    check("wr_access_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    check("wr_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd2);
    check("wr_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("wr_idle_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    tick();
    check("wr_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // Read, 3 wait states
    send(12'h008, 1'b0, 32'd0);
    bus.PREADY = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    check("rd_setup_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd2);
    check("rd_setup_paddr", {20'd0, bus.PADDR}, 32'h008);
    tick();
    pulses = 0;
    ready_seen = 0;
    for (int i = 0; i < 3; i++) begin
      check("rd_wait_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
      check("rd_wait_paddr", {20'd0, bus.PADDR}, 32'h008);
      if (bus.rsp_valid) pulses++;
      if (bus.cmd_ready) ready_seen++;
      tick();
    end
    check("rd_wait_no_rsp", pulses, 32'd0);
    check("rd_wait_no_ready", ready_seen, 32'd0);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h0000_0002;
    #1;
    check("rd_final_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    check("rd_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd2);
    check("rd_rsp_rdata", bus.rsp_rdata, 32'h2);

    // Slave error on read, then a clean read (PSLVERR ignored during SETUP)
    send(12'h010, 1'b0, 32'd0);
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'h0000_0055;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("err_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd3);
    check("err_rsp_rdata", bus.rsp_rdata, 32'h55);
    send(12'h014, 1'b0, 32'd0);
    bus.PRDATA = 32'h0000_0066;
    tick();
    bus.cmd_valid = 1'b0;
    bus.PSLVERR   = 1'b0;
    tick();
    tick();
    check("noerr_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd2);
    check("noerr_rsp_rdata", bus.rsp_rdata, 32'h66);

    // Back-to-back writes with cmd_valid held
    send(12'h000, 1'b1, 32'h0000_000A);
    tick();
    send(12'h004, 1'b1, 32'h0000_000B);
    check("b2b_1_setup_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd2);
    check("b2b_1_setup_pwdata", bus.PWDATA, 32'hA);
    check("b2b_1_setup_ready", {31'd0, bus.cmd_ready}, 32'd0);
    tick();
    check("b2b_1_access_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
    check("b2b_1_access_paddr", {20'd0, bus.PADDR}, 32'h000);
    check("b2b_1_access_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    check("b2b_2_setup_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd2);
    check("b2b_2_setup_paddr", {20'd0, bus.PADDR}, 32'h004);
    check("b2b_2_setup_pwdata", bus.PWDATA, 32'hB);
    check("b2b_1_rsp", {31'd0, bus.rsp_valid}, 32'd1);
    tick();
    check("b2b_2_access_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
    check("b2b_gap_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    check("b2b_2_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd2);
    check("b2b_end_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);

    // Reset during an ACCESS wait state
    send(12'h020, 1'b0, 32'd0);
    bus.PREADY = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    PRESET = 1'b1;
    tick();
    check("mid_rst_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    check("mid_rst_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("mid_rst_paddr", {20'd0, bus.PADDR}, 32'd0);
    PRESET     = 1'b0;
    bus.PREADY = 1'b1;
    tick();
    check("post_rst_rspv", {31'd0, bus.rsp_valid}, 32'd0);
    send(12'h030, 1'b1, 32'h0000_0077);
    tick();
    bus.cmd_valid = 1'b0;
    check("post_rst_setup", {30'd0, bus.PSEL, bus.PENABLE}, 32'd2);
    tick();
    tick();
    check("post_rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd2);
    check("post_rst_paddr_hold", {20'd0, bus.PADDR}, 32'h030);

    // Stalled slave: PREADY held low
    send(12'h040, 1'b0, 32'd0);
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'h0000_0099;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    pulses = 0;
    ready_seen = 0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      if (bus.rsp_valid) pulses++;
      if (bus.cmd_ready) ready_seen++;
      tick();
    end
    check("to_no_early_rsp", pulses, 32'd0);
    check("to_no_early_ready", ready_seen, 32'd0);
    check("to_last_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
    check("to_abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    check("to_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd3);
    check("to_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("to_idle_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
`else
    for (int i = 0; i < 1000; i++) begin
      if (bus.rsp_valid) pulses++;
      tick();
    end
    check("hang_no_rsp", pulses, 32'd0);
    check("hang_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
    check("hang_paddr", {20'd0, bus.PADDR}, 32'h040);
    PRESET = 1'b1;
    tick();
    PRESET     = 1'b0;
    bus.PREADY = 1'b1;
    check("hang_rst_ctl", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
